ahb_stream_writer: RTL

//  Upstream feeder for ahb_master's user interface (UI). Buffers a valid/ready word stream in an

---
 rtl/ahb_stream_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_stream_writer.sv
// Stream-to-UI write feeder for ahb_master: buffers a valid/ready word stream
// in a first-word-fall-through FIFO and presents one write burst per accepted
// start, inserting BUSY beats (valid=0) whenever the FIFO runs dry mid-burst.
module ahb_stream_writer #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_hclk,
  input  logic                          i_hreset_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_base_addr,
  input  logic [BEAT_WDT-1:0]           i_len,
  input  logic [2:0]                    i_size,
  input  logic [DATA_WDT-1:0]           i_s_data,
  input  logic                          i_s_valid,
  output logic                          o_s_ready,
  output logic [DATA_WDT-1:0]           o_mst_data,
  output logic                          o_mst_valid,
  output logic [31:0]                   o_mst_addr,
  output logic [2:0]                    o_mst_size,
  output logic                          o_mst_write,
  output logic                          o_mst_read,
  output logic [BEAT_WDT-1:0]           o_mst_min_len,
  output logic                          o_mst_cont,
  input  logic                          i_mst_next,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM} state_t;

  state_t              state;
  logic [DATA_WDT-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [BEAT_WDT-1:0] len_q;
  logic [BEAT_WDT-1:0] loaded;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                more;

  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign push         = i_s_valid && !full;
  assign more         = (loaded < len_q);
  // A pop is exactly a load of the head word into the UI register.
  assign pop          = !empty && ((state == FIRST) ||
                                   ((state == STREAM) && i_mst_next && more));
  assign o_s_ready    = !full;
  assign o_fifo_level = level;
  assign o_busy       = (state != IDLE);
  assign o_mst_read   = 1'b0;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_hclk) begin
    if (push) mem[wr_ptr] <= i_s_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Burst sequencer with registered UI outputs.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state         <= IDLE;
      len_q         <= '0;
      loaded        <= '0;
      o_mst_data    <= '0;
      o_mst_valid   <= 1'b0;
      o_mst_addr    <= '0;
      o_mst_size    <= '0;
      o_mst_write   <= 1'b0;
      o_mst_min_len <= '0;
      o_mst_cont    <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && (i_len != '0)) begin
            o_mst_addr    <= i_base_addr;
            o_mst_size    <= i_size;
            o_mst_min_len <= i_len;
            len_q         <= i_len;
            loaded        <= '0;
            state         <= FIRST;
          end
        end
        FIRST: begin
          // The first beat is never a BUSY beat: wait here for data.
          if (!empty) begin
            o_mst_data  <= mem[rd_ptr];
            o_mst_write <= 1'b1;
            o_mst_cont  <= 1'b0;
            o_mst_valid <= 1'b1;
            loaded      <= BEAT_WDT'(1);
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (i_mst_next) begin
            if (more) begin
              o_mst_cont <= 1'b1;
              if (!empty) begin
                o_mst_data  <= mem[rd_ptr];
                o_mst_valid <= 1'b1;
                loaded      <= loaded + BEAT_WDT'(1);
              end else begin
                o_mst_data  <= '0;
                o_mst_valid <= 1'b0;
              end
            end else begin
              o_mst_write <= 1'b0;
              o_mst_cont  <= 1'b0;
              o_mst_valid <= 1'b0;
              o_mst_data  <= '0;
              o_done      <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
